// File: rtl/led_scan_sequencer.sv
// Scanning-light sequencer feeding a 3-to-8 LED decoder: IDLE/RUN/PAUSE control,
// prescaled index stepping in up/down/bounce/hold modes, all outputs registered.
module led_scan_sequencer #(
   parameter int PRESCALE = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   input  logic [1:0] mode,
   output logic       en,
   output logic [2:0] a,
   output logic       tick,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam logic [1:0] MODE_UP     = 2'd0;
   localparam logic [1:0] MODE_DOWN   = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(PRESCALE - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dir_up;
   logic [2:0]       r_a;
   logic             r_tick;
   logic             r_en;
   logic             r_busy;

   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_do_adv;
   logic             w_clear;
   logic [2:0]       w_a_adv;
   logic             w_dir_adv;
   logic             w_moves;

   assign en   = r_en;
   assign a    = r_a;
   assign tick = r_tick;
   assign busy = r_busy;

   // Candidate index/direction if an advance happens this edge.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_a_adv   = r_a;
      w_dir_adv = r_dir_up;
      w_moves   = 1'b1;
      case (mode)
         MODE_UP: begin
            w_a_adv   = r_a + 3'd1;
            w_dir_adv = 1'b1;
         end
         MODE_DOWN: begin
            w_a_adv   = r_a - 3'd1;
            w_dir_adv = 1'b0;
         end
         MODE_BOUNCE: begin
            if (r_dir_up) begin
               if (r_a == 3'd7) begin
                  w_a_adv   = 3'd6;
                  w_dir_adv = 1'b0;
               end else begin
                  w_a_adv = r_a + 3'd1;
               end
            end else begin
               if (r_a == 3'd0) begin
                  w_a_adv   = 3'd1;
                  w_dir_adv = 1'b1;
               end else begin
                  w_a_adv = r_a - 3'd1;
               end
            end
         end
         default: w_moves = 1'b0;
      endcase
   end

   // Stop has priority over start; step is only honoured in PAUSE with no start/stop.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_do_adv    = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !stop) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (stop)                 w_state_nxt = ST_PAUSE;
            else if (r_cnt == CNT_TERM) w_do_adv  = 1'b1;
            else                      w_cnt_nxt   = r_cnt + CNT_W'(1);
         end
         ST_PAUSE: begin
            if (stop) begin
               w_state_nxt = ST_IDLE;
               w_clear     = 1'b1;
            end else if (start) begin
               w_state_nxt = ST_RUN;
            end else if (step) begin
               w_do_adv = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_dir_up <= 1'b1;
         r_a      <= 3'd0;
         r_tick   <= 1'b0;
         r_en     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_en    <= (w_state_nxt != ST_IDLE);
         r_busy  <= (w_state_nxt == ST_RUN);
         r_tick  <= w_do_adv && w_moves;
         if (w_clear) begin
            r_a      <= 3'd0;
            r_dir_up <= 1'b1;
         end else if (w_do_adv) begin
            r_a      <= w_a_adv;
            r_dir_up <= w_dir_adv;
         end
      end
   end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Self-checking bench for led_scan_sequencer: directed scenarios plus randomized
// pulses, compared every cycle against a behavioural model of the scan rules.
module tb_led_scan_sequencer;

   localparam int PRESCALE = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       step;
   logic [1:0] mode;
   logic       en;
   logic [2:0] a;
   logic       tick;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;

   led_scan_sequencer #(.PRESCALE(PRESCALE), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .step  (step),
      .mode  (mode),
      .en    (en),
      .a     (a),
      .tick  (tick),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: run age in cycles since entering RUN; bounce as a
   // position on a 14-step triangle wave.
   typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;
   mstate_t m_state;
   int      m_a;
   int      m_age;
   bit      m_dir_up;
   bit      m_tick;
   bit      m_en;
   bit      m_busy;

   function automatic void model_reset();
      m_state  = M_IDLE;
      m_a      = 0;
      m_age    = 0;
      m_dir_up = 1'b1;
      m_tick   = 1'b0;
      m_en     = 1'b0;
      m_busy   = 1'b0;
   endfunction

   function automatic void model_advance(int md);
      int p;
      case (md)
         0: begin m_a = (m_a + 1) % 8; m_dir_up = 1'b1; m_tick = 1'b1; end
         1: begin m_a = (m_a + 7) % 8; m_dir_up = 1'b0; m_tick = 1'b1; end
         2: begin
            p        = m_dir_up ? m_a : (14 - m_a) % 14;
            p        = (p + 1) % 14;
            m_a      = (p <= 7) ? p : 14 - p;
            m_dir_up = (p >= 1 && p <= 7);
            m_tick   = 1'b1;
         end
         default: ;
      endcase
   endfunction

   function automatic void model_edge(bit s, bit sp, bit stp, int md);
      m_tick = 1'b0;
      case (m_state)
         M_IDLE: if (s && !sp) begin m_state = M_RUN; m_age = 0; end
         M_RUN: begin
            if (sp) m_state = M_PAUSE;
            else begin
               m_age++;
               if (m_age % PRESCALE == 0) model_advance(md);
            end
         end
         default: begin
            if (sp) begin m_state = M_IDLE; m_a = 0; m_dir_up = 1'b1; end
            else if (s) begin m_state = M_RUN; m_age = 0; end
            else if (stp) model_advance(md);
         end
      endcase
      m_en   = (m_state != M_IDLE);
      m_busy = (m_state == M_RUN);
   endfunction

   function automatic logic [5:0] exp_vec();
      return {m_en, 3'(m_a), m_tick, m_busy};
   endfunction

   function automatic string dut_str();
      return $sformatf("en=%b a=%0d tick=%b busy=%b", en, a, tick, busy);
   endfunction

   function automatic string exp_str();
      return $sformatf("en=%b a=%0d tick=%b busy=%b", m_en, m_a, m_tick, m_busy);
   endfunction

   // Drive one cycle of inputs (from a falling edge), update the model, and
   // return at the next falling edge with pulses deasserted.
   task automatic drive(input bit s, input bit sp, input bit stp, input logic [1:0] md);
      start = s;
      stop  = sp;
      step  = stp;
      mode  = md;
      model_edge(s, sp, stp, int'(md));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      step  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      step  = 1'b0;
      mode  = 2'd0;
      model_reset();
      repeat (2) @(negedge clk);
      n_total++;
      if ({en, a, tick, busy} !== 6'b0) $display("FAIL reset_values: dut %s exp all zero", dut_str());
      else n_pass++;
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 2'd0);
      n_total++;
      if ({en, a, tick, busy} !== exp_vec()) $display("FAIL idle_ignores_stop_step: dut %s exp %s", dut_str(), exp_str());
      else n_pass++;
   endtask

   task automatic test_up();
      int ticks = 0;
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      n_total++;
      if (en !== 1'b1 || busy !== 1'b1) $display("FAIL up_start_en: dut %s exp en=1 busy=1", dut_str());
      else n_pass++;
      for (int i = 0; i < 36; i++) begin
         drive(1'b0, 1'b0, 1'b0, 2'd0);
         if (tick === 1'b1) ticks++;
         n_total++;
         if ({en, a, tick, busy} !== exp_vec()) $display("FAIL up_cyc%0d: dut %s exp %s", i, dut_str(), exp_str());
         else n_pass++;
      end
      n_total++;
      if (ticks != 9 || a !== 3'd1) $display("FAIL up_tick_count: dut ticks=%0d a=%0d exp ticks=9 a=1", ticks, a);
      else n_pass++;
   endtask

   task automatic test_down();
      drive(1'b0, 1'b1, 1'b0, 2'd0);
      drive(1'b0, 1'b1, 1'b0, 2'd0);
      n_total++;
      if (en !== 1'b0 || a !== 3'd0 || tick !== 1'b0) $display("FAIL down_to_idle: dut %s exp en=0 a=0 tick=0", dut_str());
      else n_pass++;
      drive(1'b1, 1'b0, 1'b0, 2'd1);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 1'b0, 2'd1);
         n_total++;
         if ({en, a, tick, busy} !== exp_vec()) $display("FAIL down_cyc%0d: dut %s exp %s", i, dut_str(), exp_str());
         else n_pass++;
      end
      n_total++;
      if (a !== 3'd4) $display("FAIL down_final: dut a=%0d exp a=4", a);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int prev_a;
      prev_a = int'(a);
      for (int i = 0; i < 80; i++) begin
         drive(1'b0, 1'b0, 1'b0, 2'd2);
         n_total++;
         if ({en, a, tick, busy} !== exp_vec()) $display("FAIL bounce_cyc%0d: dut %s exp %s", i, dut_str(), exp_str());
         else n_pass++;
         if (tick === 1'b1) begin
            n_total++;
            if (int'(a) == prev_a || (int'(a) - prev_a) * (int'(a) - prev_a) != 1)
               $display("FAIL bounce_unit_step%0d: dut a=%0d prev=%0d exp a=prev+-1", i, a, prev_a);
            else n_pass++;
            prev_a = int'(a);
         end
      end
   endtask

   task automatic test_pause();
      int budget = 64;
      while (!(m_a == 3 && m_tick) && budget > 0) begin
         drive(1'b0, 1'b0, 1'b0, 2'd0);
         budget--;
      end
      n_total++;
      if (budget == 0 || a !== 3'd3) $display("FAIL pause_reach_3: dut a=%0d budget=%0d exp a=3", a, budget);
      else n_pass++;
      drive(1'b0, 1'b1, 1'b0, 2'd0);
      n_total++;
      if (en !== 1'b1 || busy !== 1'b0 || a !== 3'd3) $display("FAIL pause_enter: dut %s exp en=1 busy=0 a=3", dut_str());
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 1'b0, 2'd0);
         n_total++;
         if ({en, a, tick, busy} !== exp_vec() || a !== 3'd3) $display("FAIL pause_hold%0d: dut %s exp %s", i, dut_str(), exp_str());
         else n_pass++;
      end
      drive(1'b0, 1'b0, 1'b1, 2'd0);
      n_total++;
      if (a !== 3'd4 || tick !== 1'b1) $display("FAIL pause_step: dut %s exp a=4 tick=1", dut_str());
      else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 2'd0);
      n_total++;
      if (tick !== 1'b0 || a !== 3'd4) $display("FAIL pause_step_single: dut %s exp a=4 tick=0", dut_str());
      else n_pass++;
      drive(1'b0, 1'b1, 1'b0, 2'd0);
      n_total++;
      if (en !== 1'b0 || a !== 3'd0 || tick !== 1'b0) $display("FAIL pause_stop_idle: dut %s exp en=0 a=0 tick=0", dut_str());
      else n_pass++;
   endtask

   task automatic test_start_stop_same();
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      repeat (6) drive(1'b0, 1'b0, 1'b0, 2'd0);
      drive(1'b1, 1'b1, 1'b0, 2'd0);
      n_total++;
      if (en !== 1'b1 || busy !== 1'b0) $display("FAIL same_cycle_run: dut %s exp en=1 busy=0", dut_str());
      else n_pass++;
      drive(1'b0, 1'b1, 1'b0, 2'd0);
      drive(1'b1, 1'b1, 1'b0, 2'd0);
      n_total++;
      if (en !== 1'b0 || busy !== 1'b0) $display("FAIL same_cycle_idle: dut %s exp en=0 busy=0", dut_str());
      else n_pass++;
   endtask

   task automatic test_reset_midrun();
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      repeat (9) drive(1'b0, 1'b0, 1'b0, 2'd0);
      n_total++;
      if (a !== 3'd2 || busy !== 1'b1) $display("FAIL midrun_pre: dut %s exp a=2 busy=1", dut_str());
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({en, a, tick, busy} !== 6'b0) $display("FAIL midrun_async_reset: dut %s exp all zero", dut_str());
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({en, a, tick, busy} !== 6'b0) $display("FAIL midrun_reset_held: dut %s exp all zero", dut_str());
      else n_pass++;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_hold();
      logic [2:0] held;
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      repeat (6) drive(1'b0, 1'b0, 1'b0, 2'd0);
      held = a;
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, 1'b0, 1'b0, 2'd3);
         n_total++;
         if ({en, a, tick, busy} !== exp_vec() || a !== held || tick !== 1'b0)
            $display("FAIL hold_cyc%0d: dut %s exp %s", i, dut_str(), exp_str());
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [1:0] md;
      md = mode;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 5) == 0, md);
         n_total++;
         if ({en, a, tick, busy} !== exp_vec()) $display("FAIL random_cyc%0d: dut %s exp %s", i, dut_str(), exp_str());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_up();
      test_down();
      test_bounce();
      test_pause();
      test_start_stop_same();
      test_reset_midrun();
      test_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
